fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the main control decoder in the single-cycle MIPS core. It owns the program counter and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake. It holds that word stable, presents opcode instr[31:26] to the control decoder, and computes the next PC from the decoder's branch/jump outputs and the ALU zero flag when the core retires the instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
INSTR_W, 32, instruction and address width (fixed 32; no other value supported)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (= pc while imem_req)
imem_ack  in  1  memory returns imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  held instruction for decode/register file/imm-extend
opcode  out  6  instr[31:26], to the control decoder
instr_valid  out  1  instr is valid and stable
pc  out  32  current PC
pc_plus4  out  32  pc + 4
branch  in  1  from control decoder
jump  in  1  from control decoder
zero  in  1  from ALU
advance  in  1  single-cycle pulse: the core has retired instr

Behaviour:
- Reset (async, immediate): pc=RESET_PC, instr=0, state=FETCH, instr_valid=0. imem_req is asserted as soon as rst deasserts.
- FSM states: FETCH, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack: instr<=imem_rdata, go to HOLD.
  - Ack may arrive in the first FETCH cycle, so minimum latency is one cycle from req to instr_valid.
- HOLD:
  - imem_req=0, instr_valid=1. instr and pc are frozen.
  - On advance: pc<=next_pc, go to FETCH. instr_valid drops the next cycle.
- next_pc is combinational, 32-bit modulo arithmetic:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - else branch&zero: pc_plus4 + (sign_extend(instr[15:0]) << 2)
  - else: pc_plus4
- Boundary conditions:
  - Jump has priority over branch when both are asserted.
  - A branch with zero=0 falls through to pc_plus4.
  - pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.
  - A negative branch offset may produce a target below pc; this is legal.
- Ignored inputs:
  - advance in FETCH is ignored; the PC never changes while a request is outstanding.
  - imem_ack in HOLD is ignored; instr is not overwritten.
  - branch, jump and zero are sampled only in the cycle advance=1 in HOLD.
- imem_rdata is not checked. An unknown opcode flows to the decoder, which takes its default (no-op) path.
- Reset mid-fetch: the request is abandoned and pc returns to RESET_PC. A late ack arriving in the first post-reset FETCH cycle is accepted as the RESET_PC word; the memory must guarantee this.
- Outputs opcode, pc and pc_plus4 are continuous functions of the registers.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_ADDI 6'b001000, OP_BEQ 6'b000100, OP_J 6'b000010
  - the fetch state enum
  - the default RESET_PC
- One sub-module, next_pc_calc: combinational target and priority mux. Inputs pc_plus4, instr, branch, jump, zero; output next_pc.

Test Plan:
- Reset and first fetch: assert rst, release -> imem_req=1, imem_addr=0. Ack with 32'h8C01_0004 one cycle later -> next cycle instr_valid=1, opcode=6'b100011.
- Sequential fetch: ack immediately each time, advance with branch=jump=0 -> imem_addr sequence 0x0, 0x4, 0x8.
- Branch at pc=0x10, instr 32'h1000_FFFE:
  - zero=1 -> next pc=0x0C (0x14 - 8).
  - repeat with zero=0 -> next pc=0x14.
- Jump priority: pc=0x1000_0000, instr 32'h0800_0040, branch=1, jump=1, zero=1 -> next pc=0x1000_0100.
- Handshake robustness:
  - Stall ack 5 cycles -> imem_req held, imem_addr stable, instr_valid=0.
  - advance pulsed during the stall -> pc unchanged.
  - Spurious ack in HOLD -> instr unchanged.
- Reset mid-operation: rst pulsed in HOLD at pc=0x40 -> pc=RESET_PC and instr_valid=0 immediately (asynchronous), refetch starts from RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   - opcode constants seen by the control decoder
//   - fetch stage FSM state type
//   - default program counter value after reset
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter selection for the fetch stage (purely combinational).
// Ports:
//   pc_plus4 in  32  address of the sequential successor
//   instr    in  32  currently held instruction (jump index / branch offset)
//   branch   in  1   conditional branch from the control decoder
//   jump     in  1   unconditional jump from the control decoder
//   zero     in  1   ALU zero flag, qualifies the branch
//   next_pc  out 32  selected successor address
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // Jump keeps the 256 MB region of the delay-slot address.
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  // Word offset, sign-extended; wraps modulo 2^32.
  assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  // Jump wins over branch when the decoder asserts both.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction
// over a req/ack handshake, holds it for decode and steps the PC when the
// core retires the instruction.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req/addr     fetch request and address (addr = pc)
//   imem_ack/rdata    memory response, rdata valid with ack
//   instr, opcode     held instruction and its opcode field
//   instr_valid       instr is valid and stable
//   pc, pc_plus4      current PC and its sequential successor
//   branch/jump/zero  next-PC controls, sampled only when advance in HOLD
//   advance           one-cycle pulse: instr has been retired
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc_plus4,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  input  logic               advance
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  // Request and valid flags are registered alongside the state so the
  // memory and decoder see glitch-free outputs. ack in HOLD and advance in
  // FETCH fall through the defaults and are therefore ignored.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    if (state_q == ST_FETCH) begin
      if (imem_ack) begin
        instr_d       = imem_rdata;
        state_d       = ST_HOLD;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b1;
      end
    end else begin
      if (advance) begin
        pc_d          = next_pc;
        state_d       = ST_FETCH;
        imem_req_d    = 1'b1;
        instr_valid_d = 1'b0;
      end
    end
  end

  // Request comes out of reset asserted so the first fetch is issued in
  // the very first cycle after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Two instances share all inputs: one
// with the default reset PC and one starting near the top of the address
// space so PC wrap-around is exercised. A behavioural model tracks the PC of
// each and the held instruction word.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] LO_RESET = 32'h0000_0000;
  localparam logic [31:0] HI_RESET = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch = 1'b0, jump = 1'b0, zero = 1'b0, advance = 1'b0;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        imem_req_h, instr_valid_h;
  logic [31:0] imem_addr_h, instr_h, pc_h, pc_plus4_h;
  logic [5:0]  opcode_h;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;
  logic [31:0] m_pc_lo, m_pc_hi, m_instr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(LO_RESET)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .branch(branch), .jump(jump), .zero(zero), .advance(advance)
  );

  fetch_unit #(.RESET_PC(HI_RESET)) u_dut_hi (
    .clk(clk), .rst(rst), .imem_req(imem_req_h), .imem_addr(imem_addr_h),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_h),
    .opcode(opcode_h), .instr_valid(instr_valid_h), .pc(pc_h),
    .pc_plus4(pc_plus4_h), .branch(branch), .jump(jump), .zero(zero),
    .advance(advance)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural successor rule, written with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc,
      input logic [31:0] word, input logic b, input logic j, input logic z);
    logic [31:0] p4;
    int          off;
    p4 = cur_pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | (32'(word & 32'h03FF_FFFF) * 32'd4);
    if (b && z) begin
      off = int'($signed(word[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch: stall `delay` cycles (with random advance pulses that
  // must be ignored), then ack with `word`.
  task automatic do_fetch(input logic [31:0] word, input int delay);
    check_val("req_on", {31'd0, imem_req}, 32'd1);
    check_val("addr", imem_addr, m_pc_lo);
    check_val("addr_hi", imem_addr_h, m_pc_hi);
    for (int i = 0; i < delay; i++) begin
      advance = 1'($urandom_range(0, 1));
      jump    = 1'($urandom_range(0, 1));
      tick();
      check_val("stall_req", {31'd0, imem_req}, 32'd1);
      check_val("stall_valid", {31'd0, instr_valid}, 32'd0);
      check_val("stall_pc", pc, m_pc_lo);
    end
    advance    = 1'b0;
    jump       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = word;
    check_val("valid", {31'd0, instr_valid}, 32'd1);
    check_val("req_off", {31'd0, imem_req}, 32'd0);
    check_val("instr", instr, m_instr);
    check_val("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
    check_val("instr_hi", instr_h, m_instr);
  endtask

  // Hold for `idle` cycles (optionally with spurious acks), then retire.
  task automatic do_retire(input logic b, input logic j, input logic z,
                           input int idle, input logic spurious);
    logic [31:0] old_pc;
    for (int i = 0; i < idle; i++) begin
      imem_ack   = spurious;
      imem_rdata = $urandom;
      branch     = 1'($urandom_range(0, 1));
      tick();
      check_val("hold_instr", instr, m_instr);
      check_val("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    branch = b; jump = j; zero = z; advance = 1'b1;
    tick();
    advance = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    old_pc  = m_pc_lo;
    m_pc_lo = ref_next(m_pc_lo, m_instr, b, j, z);
    m_pc_hi = ref_next(m_pc_hi, m_instr, b, j, z);
    check_val("next_pc", pc, m_pc_lo);
    check_val("pc_plus4", pc_plus4, m_pc_lo + 32'd4);
    check_val("next_pc_hi", pc_h, m_pc_hi);
    check_val("drop_valid", {31'd0, instr_valid}, 32'd0);
    $display("txn %0d pc=%h instr=%h b=%0b j=%0b z=%0b -> pc=%h hi_pc=%h",
             txn, old_pc, m_instr, b, j, z, pc, pc_h);
    txn++;
  endtask

  initial begin
    logic [31:0] w;
    m_pc_lo = LO_RESET;
    m_pc_hi = HI_RESET;
    m_instr = '0;

    // Reset state
    tick();
    tick();
    check_val("rst_pc", pc, LO_RESET);
    check_val("rst_pc_hi", pc_h, HI_RESET);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    rst = 1'b0;

    // First fetch (lw), then sequential; high instance wraps to 0
    do_fetch(32'h8C01_0004, 1);
    do_retire(1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_fetch(32'h0000_0020, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1, 1'b1);
    // Jump to 0x10, branch back taken, jump again, branch not taken
    do_fetch(32'h0800_0004, 0);
    do_retire(1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_fetch(32'h1000_FFFE, 5);
    do_retire(1'b1, 1'b0, 1'b1, 2, 1'b1);
    check_val("beq_taken", pc, 32'h0000_000C);
    do_fetch(32'h0800_0004, 0);
    do_retire(1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_fetch(32'h1000_FFFE, 0);
    do_retire(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_val("beq_not_taken", pc, 32'h0000_0014);
    // Jump and branch together: jump wins
    do_fetch(32'h0800_0040, 0);
    do_retire(1'b1, 1'b1, 1'b1, 0, 1'b0);
    check_val("jump_prio", pc, 32'h0000_0100);
    // Reach pc=0x40 and reset while holding
    do_fetch(32'h0800_0010, 0);
    do_retire(1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_fetch(32'h2001_0005, 2);
    #3 rst = 1'b1;
    #1;
    check_val("midrst_pc", pc, LO_RESET);
    check_val("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("midrst_instr", instr, 32'd0);
    check_val("midrst_pc_hi", pc_h, HI_RESET);
    tick();
    rst = 1'b0;
    m_pc_lo = LO_RESET;
    m_pc_hi = HI_RESET;
    m_instr = '0;

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:26] = OP_BEQ;
        1: w[31:26] = OP_J;
        2: w[31:26] = OP_LW;
        default: ;
      endcase
      do_fetch(w, $urandom_range(0, 3));
      do_retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
